// File: rtl/i2s_tx_core.sv
// I2S transmitter core: frame FIFO, BCLK/LRCLK divider and MSB-first serialiser.
// Optional build macro I2S_TX_LEFT_JUSTIFIED_EN selects left-justified LRCLK alignment
// (LRCLK edge on the MSB); undefined gives standard I2S with a one-bit delay.
module i2s_tx_core #(
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable_i,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [SAMPLE_W-1:0]               wr_left_i,
  input  logic [SAMPLE_W-1:0]               wr_right_i,
  input  logic                              underrun_clr_i,
  output logic                              bclk_o,
  output logic                              lrclk_o,
  output logic                              sdata_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  output logic                              underrun_o,
  output logic                              irq_o
);

  localparam int unsigned FrameW = 2 * SAMPLE_W;
  localparam int unsigned SlotW  = $clog2(FrameW);
  localparam int unsigned DivW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(FrameW - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(BCLK_DIV - 1);
  localparam logic [LvlW-1:0]  LvlFull  = LvlW'(FIFO_DEPTH);

  logic [FrameW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic [DivW-1:0]   div_q;
  logic [SlotW-1:0]  slot_q;
  logic [FrameW-1:0] shift_q;
  logic              run_q, bclk_q, lrclk_q, sdata_q, underrun_q;

  logic              wr_fire, div_tc, start, fall, wrap, load, fifo_empty, pop;
  logic [SlotW-1:0]  slot_nxt;
  logic [FrameW-1:0] load_frame;

  // LRCLK level for a given slot number.
  function automatic logic lr_of(input logic [SlotW-1:0] s);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return s >= SlotW'(SAMPLE_W);
`else
    return (s >= SlotW'(SAMPLE_W - 1)) && (s <= SlotW'(FrameW - 2));
`endif
  endfunction

  // Strobes for write, divider terminal count, slot advance and frame load.
  always_comb begin
    wr_ready_o = (level_q != LvlFull);
    wr_fire    = wr_valid_i && wr_ready_o;
    div_tc     = (div_q == DivLast);
    start      = enable_i && !run_q;
    fall       = enable_i && run_q && div_tc && bclk_q;
    wrap       = fall && (slot_q == SlotLast);
    load       = start || wrap;
    fifo_empty = (level_q == '0);
    pop        = load && !fifo_empty;
    load_frame = pop ? mem_q[rd_ptr_q] : '0;
    slot_nxt   = (start || wrap) ? '0 : slot_q + SlotW'(1);
  end

  // FIFO storage; contents need no reset since level/pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= {wr_left_i, wr_right_i};
    end
  end

  // FIFO bookkeeping, underrun flag, divider, slot counter and serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      run_q      <= 1'b0;
      div_q      <= '0;
      slot_q     <= '0;
      shift_q    <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_fire, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase

      // A load from an empty FIFO beats a clear in the same cycle.
      if (load && fifo_empty) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr_i) begin
        underrun_q <= 1'b0;
      end

      if (!enable_i) begin
        // Stopped: partial frame is dropped, everything parks at zero.
        run_q   <= 1'b0;
        div_q   <= '0;
        slot_q  <= '0;
        shift_q <= '0;
        bclk_q  <= 1'b0;
        lrclk_q <= 1'b0;
        sdata_q <= 1'b0;
      end else if (start) begin
        run_q   <= 1'b1;
        div_q   <= '0;
        bclk_q  <= 1'b0;
        slot_q  <= slot_nxt;
        lrclk_q <= lr_of(slot_nxt);
        sdata_q <= load_frame[FrameW-1];
        shift_q <= {load_frame[FrameW-2:0], 1'b0};
      end else begin
        div_q <= div_tc ? '0 : div_q + DivW'(1);
        if (div_tc) bclk_q <= ~bclk_q;
        if (fall) begin
          slot_q  <= slot_nxt;
          lrclk_q <= lr_of(slot_nxt);
          if (wrap) begin
            sdata_q <= load_frame[FrameW-1];
            shift_q <= {load_frame[FrameW-2:0], 1'b0};
          end else begin
            sdata_q <= shift_q[FrameW-1];
            shift_q <= {shift_q[FrameW-2:0], 1'b0};
          end
        end
      end
    end
  end

  // Output decode; irq is held low while reset is asserted.
  always_comb begin
    bclk_o       = bclk_q;
    lrclk_o      = lrclk_q;
    sdata_o      = sdata_q;
    fifo_level_o = level_q;
    underrun_o   = underrun_q;
    irq_o        = !rst && enable_i && (32'(level_q) <= LOW_WATER);
  end

endmodule

// File: tb/tb_i2s_tx_core.sv
// Self-checking bench for i2s_tx_core with a cycle-indexed reference model.
module tb_i2s_tx_core;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int DIV = 2;
  localparam int LW  = 2;
  localparam int P   = 4 * W * DIV;
  localparam int LVW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           enable, wr_valid, wr_ready, underrun_clr;
  logic [W-1:0]   wr_left, wr_right;
  logic           bclk, lrclk, sdata, underrun, irq;
  logic [LVW-1:0] fifo_level;

  logic [2*W-1:0] q[$];
  logic           exp_und;
  int             vec, errs;

  i2s_tx_core #(
    .SAMPLE_W(W), .FIFO_DEPTH(D), .BCLK_DIV(DIV), .LOW_WATER(LW)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_left_i(wr_left), .wr_right_i(wr_right), .underrun_clr_i(underrun_clr),
    .bclk_o(bclk), .lrclk_o(lrclk), .sdata_o(sdata), .fifo_level_o(fifo_level),
    .underrun_o(underrun), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_lr(int s);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return s >= W;
`else
    return (s >= W - 1) && (s <= 2 * W - 2);
`endif
  endfunction

  task automatic write_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    wr_left  = l;
    wr_right = r;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    q.push_back({l, r});
  endtask

  // Raise enable and check every cycle against the frame-stream model for 'cycles' cycles.
  task automatic stream(input int cycles);
    int n0 = q.size();
    int loaded;
    enable = 1'b1;
    tick();
    for (int t = 0; t < cycles; t++) begin
      int f = t / P;
      int k = (t / (2 * DIV)) % (2 * W);
      logic [2*W-1:0] fr;
      logic e_bclk, e_lr, e_sd, e_und, e_irq;
      int e_lvl;
      fr     = (f < n0) ? q[f] : '0;
      e_sd   = fr[2*W-1-k];
      e_bclk = ((t / DIV) % 2) == 1;
      e_lr   = exp_lr(k);
      e_lvl  = n0 - (((f + 1) < n0) ? (f + 1) : n0);
      e_und  = exp_und || (f >= n0);
      e_irq  = (e_lvl <= LW);
      vec += 6;
      if (sdata !== e_sd) begin
        errs++; $display("FAIL sdata t=%0d slot=%0d got %b want %b", t, k, sdata, e_sd);
      end
      if (bclk !== e_bclk) begin
        errs++; $display("FAIL bclk t=%0d got %b want %b", t, bclk, e_bclk);
      end
      if (lrclk !== e_lr) begin
        errs++; $display("FAIL lrclk t=%0d slot=%0d got %b want %b", t, k, lrclk, e_lr);
      end
      if (int'(fifo_level) !== e_lvl) begin
        errs++; $display("FAIL level t=%0d got %0d want %0d", t, fifo_level, e_lvl);
      end
      if (underrun !== e_und) begin
        errs++; $display("FAIL underrun t=%0d got %b want %b", t, underrun, e_und);
      end
      if (irq !== e_irq || wr_ready !== 1'b1) begin
        errs++; $display("FAIL irq/ready t=%0d got %b/%b want %b/1", t, irq, wr_ready, e_irq);
      end
      if (t == cycles - 1) exp_und = e_und;
      if (t < cycles - 1) tick();
    end
    loaded = ((cycles - 1) / P) + 1;
    if (loaded > n0) loaded = n0;
    for (int i = 0; i < loaded; i++) void'(q.pop_front());
  endtask

  task automatic check_idle(input string tag);
    vec++;
    if ({bclk, lrclk, sdata} !== 3'b000 || int'(fifo_level) !== q.size()) begin
      errs++;
      $display("FAIL %s got bclk/lr/sd=%b%b%b lvl=%0d want 000 lvl=%0d",
               tag, bclk, lrclk, sdata, fifo_level, q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({bclk, lrclk, sdata, underrun, irq, wr_ready} !== 6'b000001 || fifo_level !== '0) begin
      errs++;
      $display("FAIL reset got b/l/s/u/i/r=%b%b%b%b%b%b lvl=%0d want 000001 lvl=0",
               bclk, lrclk, sdata, underrun, irq, wr_ready, fifo_level);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < D; i++) write_frame(W'($urandom), W'($urandom));
    wr_left = W'($urandom); wr_right = W'($urandom); wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    vec++;
    if (wr_ready !== 1'b0 || int'(fifo_level) !== D || irq !== 1'b0) begin
      errs++;
      $display("FAIL full got ready=%b lvl=%0d irq=%b want 0 %0d 0", wr_ready, fifo_level, irq, D);
    end
    stream(P * (D + 1));
    enable = 1'b0;
    tick();
    check_idle("stop_after_full");
  endtask

  task automatic test_underrun_clr();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    vec++;
    if (underrun !== 1'b0) begin
      errs++; $display("FAIL und_clr got %b want 0", underrun);
    end
    enable = 1'b1;
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    vec++;
    if (underrun !== 1'b1 || sdata !== 1'b0) begin
      errs++; $display("FAIL und_set_wins got u=%b sd=%b want 1 0", underrun, sdata);
    end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    vec++;
    if (underrun !== 1'b0) begin
      errs++; $display("FAIL und_clr_run got %b want 0", underrun);
    end
    enable = 1'b0;
    tick();
    exp_und = 1'b0;
    check_idle("stop_after_clr");
  endtask

  task automatic test_pattern();
    write_frame(16'hA5F0, 16'h0F0F);
    write_frame(W'($urandom), W'($urandom));
    write_frame(W'($urandom), W'($urandom));
    vec++;
    if (irq !== 1'b0 || int'(fifo_level) !== 3) begin
      errs++; $display("FAIL pre_pattern got irq=%b lvl=%0d want 0 3", irq, fifo_level);
    end
    stream(P + P / 2);
    enable = 1'b0;
    tick();
    check_idle("mid_frame_stop");
    stream(P + 10);
    enable = 1'b0;
    tick();
    check_idle("stop_after_pattern");
  endtask

  task automatic test_reset_mid();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    exp_und = 1'b0;
    write_frame(W'($urandom), W'($urandom));
    write_frame(W'($urandom), W'($urandom));
    stream(7 * 2 * DIV + 1);
    #3 rst = 1'b1;
    #1;
    q.delete();
    exp_und = 1'b0;
    vec++;
    if ({bclk, lrclk, sdata, underrun, irq, wr_ready} !== 6'b000001 || fifo_level !== '0) begin
      errs++;
      $display("FAIL reset_mid got b/l/s/u/i/r=%b%b%b%b%b%b lvl=%0d want 000001 lvl=0",
               bclk, lrclk, sdata, underrun, irq, wr_ready, fifo_level);
    end
    #2 rst = 1'b0;
    stream(P + 5);
    enable = 1'b0;
    tick();
  endtask

  initial begin
    vec = 0;
    errs = 0;
    exp_und = 1'b0;
    rst = 1'b1;
    enable = 1'b0;
    wr_valid = 1'b0;
    underrun_clr = 1'b0;
    wr_left = '0;
    wr_right = '0;
    test_reset();
    test_fifo_full();
    test_underrun_clr();
    test_pattern();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
